uart_axis_xcvr: RTL and testbench

- Full-duplex 8N1 UART with AXI-Stream byte interfaces on a single clock.
- RX path deserialises i_rxd into bytes and presents them on an AXIS master port, optionally through a byte FIFO.
- TX path accepts bytes on an AXIS slave port and serialises them onto o_txd.
- Used as the host serial bridge. Looping the master port to the slave port forms an echo.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_axis_xcvr.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_axis_xcvr.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART / AXI-Stream transceiver.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO; a count register separates full from empty and
// the head entry is read straight out of the storage flops.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign empty   = (count_r == {CNT_W{1'b0}});
  assign full    = (count_r == CNT_W'(DEPTH));
  assign rd_ok_s = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
  assign wr_ok_s = wr_en & (~full | rd_ok_s);
  assign rd_data = mem_r[rd_ptr_r];

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r <= count_r + CNT_W'(wr_ok_s) - CNT_W'(rd_ok_s);
    end
  end

endmodule

// File: rtl/uart_axis_xcvr.sv
// Full-duplex 8N1 UART bridged to AXI-Stream byte ports; RX bytes are
// buffered in a FIFO or a single holding register, TX is unbuffered.
module uart_axis_xcvr
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int USE_FIFO     = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_m_axis_tdata,
  output logic       o_m_axis_tvalid,
  input  logic       i_m_axis_tready,
  input  logic [7:0] i_s_axis_tdata,
  input  logic       i_s_axis_tvalid,
  output logic       o_s_axis_tready,
  output logic       o_txd,
  output logic       o_txd_busy,
  output logic       o_txd_done,
  output logic       o_rx_frame_err,
  output logic       o_rx_overflow
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

  logic [1:0]       rxd_sync_r;
  logic             rxd_s;
  rx_state_t        rx_state_r, rx_state_n;
  logic [CNT_W-1:0] rx_cnt_r, rx_cnt_n;
  logic [2:0]       rx_bit_r, rx_bit_n;
  logic [7:0]       rx_shift_r, rx_shift_n;
  logic             rx_good_s, rx_bad_s;
  logic             rx_err_r;
  logic             m_tvalid_s, rx_ovf_s;
  logic [7:0]       m_tdata_s;

  tx_state_t        tx_state_r, tx_state_n;
  logic [CNT_W-1:0] tx_cnt_r, tx_cnt_n;
  logic [2:0]       tx_bit_r, tx_bit_n;
  logic [7:0]       tx_shift_r, tx_shift_n;
  logic             tx_line_r, tx_line_n;
  logic             tx_ready_r, tx_ready_n;
  logic             tx_busy_r, tx_busy_n;
  logic             tx_done_r, tx_done_n;

  assign rxd_s = rxd_sync_r[1];

  // Two-flop synchroniser for the asynchronous receive line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxd_sync_r <= {2{IDLE_LEVEL}};
    end else begin
      rxd_sync_r <= {rxd_sync_r[0], i_rxd};
    end
  end

  // RX next-state: half-bit start check, then one sample per bit period
  always_comb begin
    rx_state_n = rx_state_r;
    rx_cnt_n   = rx_cnt_r + CNT_ONE;
    rx_bit_n   = rx_bit_r;
    rx_shift_n = rx_shift_r;
    rx_good_s  = 1'b0;
    rx_bad_s   = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        rx_cnt_n = CNT_ZERO;
        rx_bit_n = 3'd0;
        if (rxd_s == 1'b0) rx_state_n = RX_START;
        else               rx_state_n = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_r == HALF_CNT) begin
          rx_cnt_n = CNT_ZERO;
          if (rxd_s == 1'b0) rx_state_n = RX_DATA;
          else               rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_cnt_r == LAST_CNT) begin
          rx_cnt_n   = CNT_ZERO;
          rx_shift_n = {rxd_s, rx_shift_r[7:1]};
          rx_bit_n   = rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_n = RX_STOP;
          else                  rx_state_n = RX_DATA;
        end else begin
          rx_state_n = RX_DATA;
        end
      end
      RX_STOP: begin
        if (rx_cnt_r == LAST_CNT) begin
          rx_state_n = RX_IDLE;
          rx_good_s  = rxd_s;
          rx_bad_s   = ~rxd_s;
        end else begin
          rx_state_n = RX_STOP;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state registers and frame-error pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CNT_ZERO;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
      rx_err_r   <= 1'b0;
    end else begin
      rx_state_r <= rx_state_n;
      rx_cnt_r   <= rx_cnt_n;
      rx_bit_r   <= rx_bit_n;
      rx_shift_r <= rx_shift_n;
      rx_err_r   <= rx_bad_s;
    end
  end

  generate
    if (USE_FIFO != 0) begin : g_fifo
      logic       push_r, ovf_r, full_s, empty_s, pop_s;
      logic [7:0] head_s;

      assign pop_s = ~empty_s & i_m_axis_tready;

      // Delayed write strobe and overflow pulse for the FIFO path
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          push_r <= 1'b0;
          ovf_r  <= 1'b0;
        end else begin
          push_r <= rx_good_s;
          ovf_r  <= push_r & full_s & ~pop_s;
        end
      end

      uart_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
      ) u_fifo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .wr_en  (push_r),
        .wr_data(rx_shift_r),
        .full   (full_s),
        .rd_en  (pop_s),
        .rd_data(head_s),
        .empty  (empty_s)
      );

      assign m_tvalid_s = ~empty_s;
      assign m_tdata_s  = head_s;
      assign rx_ovf_s   = ovf_r;
    end else begin : g_hold
      logic       valid_r, ovf_r;
      logic [7:0] data_r;

      // Holding register: a new byte replaces the old only if it is taken this cycle
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid_r <= 1'b0;
          data_r  <= 8'h00;
          ovf_r   <= 1'b0;
        end else begin
          ovf_r <= 1'b0;
          if (rx_good_s) begin
            if (!valid_r || i_m_axis_tready) begin
              valid_r <= 1'b1;
              data_r  <= rx_shift_r;
            end else begin
              ovf_r <= 1'b1;
            end
          end else if (valid_r && i_m_axis_tready) begin
            valid_r <= 1'b0;
          end
        end
      end

      assign m_tvalid_s = valid_r;
      assign m_tdata_s  = data_r;
      assign rx_ovf_s   = ovf_r;
    end
  endgenerate

  // TX next-state: outputs are computed for the state being entered
  always_comb begin
    tx_state_n = tx_state_r;
    tx_cnt_n   = tx_cnt_r + CNT_ONE;
    tx_bit_n   = tx_bit_r;
    tx_shift_n = tx_shift_r;
    tx_line_n  = tx_line_r;
    tx_ready_n = tx_ready_r;
    tx_busy_n  = tx_busy_r;
    tx_done_n  = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        tx_cnt_n = CNT_ZERO;
        tx_bit_n = 3'd0;
        if (i_s_axis_tvalid && tx_ready_r) begin
          tx_state_n = TX_START;
          tx_shift_n = i_s_axis_tdata;
          tx_line_n  = 1'b0;
          tx_ready_n = 1'b0;
          tx_busy_n  = 1'b1;
        end else begin
          tx_state_n = TX_IDLE;
          tx_line_n  = IDLE_LEVEL;
          tx_ready_n = 1'b1;
          tx_busy_n  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_r == LAST_CNT) begin
          tx_cnt_n   = CNT_ZERO;
          tx_state_n = TX_DATA;
          tx_line_n  = tx_shift_r[0];
        end else begin
          tx_state_n = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_cnt_r == LAST_CNT) begin
          tx_cnt_n   = CNT_ZERO;
          tx_bit_n   = tx_bit_r + 3'd1;
          tx_shift_n = {1'b0, tx_shift_r[7:1]};
          if (tx_bit_r == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_line_n  = IDLE_LEVEL;
          end else begin
            tx_state_n = TX_DATA;
            tx_line_n  = tx_shift_r[1];
          end
        end else begin
          tx_state_n = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_cnt_r == LAST_CNT) begin
          tx_state_n = TX_IDLE;
          tx_line_n  = IDLE_LEVEL;
          tx_ready_n = 1'b1;
          tx_busy_n  = 1'b0;
          tx_done_n  = 1'b1;
        end else begin
          tx_state_n = TX_STOP;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // TX state and registered line/handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_cnt_r   <= CNT_ZERO;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_line_r  <= IDLE_LEVEL;
      tx_ready_r <= 1'b1;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_state_r <= tx_state_n;
      tx_cnt_r   <= tx_cnt_n;
      tx_bit_r   <= tx_bit_n;
      tx_shift_r <= tx_shift_n;
      tx_line_r  <= tx_line_n;
      tx_ready_r <= tx_ready_n;
      tx_busy_r  <= tx_busy_n;
      tx_done_r  <= tx_done_n;
    end
  end

  assign o_m_axis_tdata  = m_tdata_s;
  assign o_m_axis_tvalid = m_tvalid_s;
  assign o_rx_overflow   = rx_ovf_s;
  assign o_rx_frame_err  = rx_err_r;
  assign o_txd           = tx_line_r;
  assign o_s_axis_tready = tx_ready_r;
  assign o_txd_busy      = tx_busy_r;
  assign o_txd_done      = tx_done_r;

endmodule

// File: tb/tb_uart_axis_xcvr.sv
// Directed bench: a FIFO-mode transceiver (depth 4) with switchable loopback,
// plus a holding-register instance sharing the same receive line.
module tb_uart_axis_xcvr;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       loop;
  logic [7:0] tb_s_tdata;
  logic       tb_s_tvalid, tb_m_tready;

  logic [7:0] m_tdata, s_tdata;
  logic       m_tvalid, m_tready, s_tvalid, s_tready;
  logic       txd, busy, done, ferr, ovf;

  logic [7:0] r_tdata;
  logic       r_tvalid, r_tready, r_s_tready, r_txd, r_busy, r_done, r_ferr, r_ovf;

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, vseen = 0, r_ovf_cnt = 0;
  logic [7:0] rxq [$];

  assign s_tvalid = loop ? m_tvalid : tb_s_tvalid;
  assign s_tdata  = loop ? m_tdata  : tb_s_tdata;
  assign m_tready = loop ? s_tready : tb_m_tready;

  always #5 clk = ~clk;

  uart_axis_xcvr #(.CLKS_PER_BIT(CPB), .USE_FIFO(1), .FIFO_DEPTH(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd),
    .o_m_axis_tdata(m_tdata), .o_m_axis_tvalid(m_tvalid), .i_m_axis_tready(m_tready),
    .i_s_axis_tdata(s_tdata), .i_s_axis_tvalid(s_tvalid), .o_s_axis_tready(s_tready),
    .o_txd(txd), .o_txd_busy(busy), .o_txd_done(done),
    .o_rx_frame_err(ferr), .o_rx_overflow(ovf)
  );

  uart_axis_xcvr #(.CLKS_PER_BIT(CPB), .USE_FIFO(0), .FIFO_DEPTH(4)) u_reg (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(rxd),
    .o_m_axis_tdata(r_tdata), .o_m_axis_tvalid(r_tvalid), .i_m_axis_tready(r_tready),
    .i_s_axis_tdata(8'h00), .i_s_axis_tvalid(1'b0), .o_s_axis_tready(r_s_tready),
    .o_txd(r_txd), .o_txd_busy(r_busy), .o_txd_done(r_done),
    .o_rx_frame_err(r_ferr), .o_rx_overflow(r_ovf)
  );

  // Pulse counters and accepted-byte log, sampled away from the active edge
  always @(negedge clk) begin
    done_cnt  <= done_cnt + int'(done);
    ferr_cnt  <= ferr_cnt + int'(ferr);
    ovf_cnt   <= ovf_cnt + int'(ovf);
    vseen     <= vseen + int'(m_tvalid);
    r_ovf_cnt <= r_ovf_cnt + int'(r_ovf);
    if (m_tvalid && m_tready) rxq.push_back(m_tdata);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input int extra);
    rxd = 1'b0;
    cyc(CPB + extra);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(CPB);
    end
    rxd = stop_lvl;
    cyc(CPB);
    rxd = 1'b1;
  endtask

  task automatic decode_tx(output logic [7:0] d, output logic ok);
    int t;
    d  = 8'h00;
    ok = 1'b0;
    t  = 0;
    while (txd !== 1'b0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (txd === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      ok = (txd === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        d[i] = txd;
      end
      repeat (CPB) @(negedge clk);
      ok = ok & (txd === 1'b1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] dec;
    logic       dok;
    logic [7:0] exp3 [3];
    int d0, f0, o0, v0, r0, qb;

    rst_n = 1'b0; rxd = 1'b1; loop = 1'b0;
    tb_s_tdata = 8'h00; tb_s_tvalid = 1'b0; tb_m_tready = 1'b0; r_tready = 1'b0;
    cyc(3);
    check_eq("rst_txd", txd, 1);
    check_eq("rst_s_tready", s_tready, 1);
    check_eq("rst_m_tvalid", m_tvalid, 0);
    check_eq("rst_m_tdata", m_tdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ferr", ferr, 0);
    check_eq("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    cyc(5);

    // Loopback echo of 0x55 with a start bit stretched by 1/8 bit
    loop = 1'b1;
    d0 = done_cnt;
    fork
      send_byte(8'h55, 1'b1, CPB / 8);
      decode_tx(dec, dok);
    join
    cyc(20);
    check_eq("loop_frame_ok", dok, 1);
    check_eq("loop_data", dec, 8'h55);
    check_eq("loop_done_pulses", done_cnt - d0, 1);
    check_eq("loop_m_tvalid_after", m_tvalid, 0);
    check_eq("reg_hold_valid", r_tvalid, 1);
    check_eq("reg_hold_data", r_tdata, 8'h55);
    loop = 1'b0;

    // Three back-to-back bytes held while tready is low, then drained in order
    o0 = ovf_cnt; r0 = r_ovf_cnt;
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'hA3;
    for (int i = 0; i < 3; i++) send_byte(exp3[i], 1'b1, 0);
    cyc(4);
    check_eq("b2b_no_ovf", ovf_cnt - o0, 0);
    check_eq("reg_drop_count", r_ovf_cnt - r0, 3);
    check_eq("reg_data_stable", r_tdata, 8'h55);
    tb_m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("b2b_tvalid", m_tvalid, 1);
      check_eq("b2b_tdata", m_tdata, exp3[i]);
      cyc(1);
    end
    check_eq("b2b_drained", m_tvalid, 0);
    tb_m_tready = 1'b0;
    r_tready = 1'b1;
    cyc(1);
    r_tready = 1'b0;
    check_eq("reg_accept_clears", r_tvalid, 0);

    // Five bytes into a 4-deep FIFO: the fifth is dropped
    o0 = ovf_cnt; r0 = r_ovf_cnt;
    for (int i = 1; i <= 5; i++) send_byte(8'(i * 17), 1'b1, 0);
    cyc(4);
    check_eq("ovf_pulses", ovf_cnt - o0, 1);
    check_eq("reg_first_kept", r_tdata, 8'h11);
    check_eq("reg_ovf_pulses", r_ovf_cnt - r0, 4);
    qb = rxq.size();
    tb_m_tready = 1'b1;
    cyc(8);
    check_eq("ovf_drain_count", rxq.size() - qb, 4);
    for (int i = 0; i < 4; i++) check_eq("ovf_drain_data", rxq[qb + i], 8'((i + 1) * 17));
    check_eq("ovf_empty", m_tvalid, 0);

    // Low stop bit: frame error, nothing delivered; next good frame delivered
    tb_m_tready = 1'b0;
    f0 = ferr_cnt; v0 = vseen;
    send_byte(8'h3C, 1'b0, 0);
    cyc(24);
    check_eq("ferr_pulse", ferr_cnt - f0, 1);
    check_eq("ferr_no_tvalid", vseen - v0, 0);
    tb_m_tready = 1'b1;
    qb = rxq.size();
    send_byte(8'h3C, 1'b1, 0);
    cyc(6);
    check_eq("ferr_next_count", rxq.size() - qb, 1);
    check_eq("ferr_next_data", rxq[qb], 8'h3C);
    check_eq("ferr_next_no_err", ferr_cnt - f0, 1);

    // Short low glitch is rejected
    f0 = ferr_cnt; v0 = vseen;
    rxd = 1'b0;
    cyc(3);
    rxd = 1'b1;
    cyc(40);
    check_eq("glitch_no_tvalid", vseen - v0, 0);
    check_eq("glitch_no_ferr", ferr_cnt - f0, 0);

    // Reset mid-frame on both paths
    tb_s_tdata = 8'hC3; tb_s_tvalid = 1'b1;
    rxd = 1'b0;
    cyc(1);
    tb_s_tvalid = 1'b0;
    cyc(40);
    check_eq("mid_tx_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_txd", txd, 1);
    check_eq("async_rst_tready", s_tready, 1);
    check_eq("async_rst_busy", busy, 0);
    check_eq("async_rst_tvalid", m_tvalid, 0);
    rxd = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    v0 = vseen;
    cyc(200);
    check_eq("rst_no_partial", vseen - v0, 0);
    check_eq("rst_txd_idle", txd, 1);
    loop = 1'b1;
    d0 = done_cnt;
    fork
      send_byte(8'h81, 1'b1, 0);
      decode_tx(dec, dok);
    join
    cyc(20);
    check_eq("post_rst_frame_ok", dok, 1);
    check_eq("post_rst_data", dec, 8'h81);
    check_eq("post_rst_done", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
